mips_alu_regfile: RTL and testbench
===================================

Name: mips_alu_regfile

Overview:
- Combined execution core for the multicycle MIPS datapath: a 32-entry x 32-bit register file (two read ports, one write port) plus a 32-bit combinational ALU with a zero flag.
- The datapath drives register addresses from the instruction fields, latches the read data into its own A/B registers, and feeds the ALU through its source muxes.
- The two halves share only clk and reset; there is no internal path between them.

Parameters:
- DATA_W, 32, data width of registers and ALU operands.
- ADDR_W, 5, register address width; register count is 2**ADDR_W.

Ports:
- clk  in  1  clock; register writes on rising edge.
- reset  in  1  asynchronous, active-high; clears all registers.
- we3  in  1  register write enable.
- ra1  in  ADDR_W  read address port 1 (instr[25:21]).
- ra2  in  ADDR_W  read address port 2 (instr[20:16]).
- wa3  in  ADDR_W  write address.
- wd3  in  DATA_W  write data.
- rd1  out  DATA_W  read data port 1.
- rd2  out  DATA_W  read data port 2.
- a  in  DATA_W  ALU operand A.
- b  in  DATA_W  ALU operand B.
- alucont  in  3  ALU operation select.
- result  out  DATA_W  ALU result.
- zero  out  1  high when result == 0.

Behaviour:
Register file:
- Reset: asserting reset immediately clears all registers to 0, independent of clk. While reset is high, writes are ignored.
- Write: on a rising clk edge with we3=1 and reset=0, reg[wa3] <= wd3.
- Writes to address 0 are discarded. Register 0 always reads 0.
- Reads are combinational: rd1 = reg[ra1] and rd2 = reg[ra2], with zero-cycle latency.
- Read-during-write to the same address: the read ports return the old value until the clock edge, then the new value. There is no write-to-read bypass.
- Both ports may read the same address simultaneously.
- rd1 and rd2 depend on no other inputs and are 0 while reset is asserted.

ALU (purely combinational; no reset dependence):
- alucont 000: A & B.
- alucont 001: A | B.
- alucont 010: A + B, modulo 2^32; carry and overflow discarded.
- alucont 011: result 0 (reserved).
- alucont 100: A & ~B.
- alucont 101: A | ~B.
- alucont 110: A - B, modulo 2^32.
- alucont 111: SLT; result is 1 when A < B as signed two's complement, else 0.
- SLT must use a true signed compare. It must not use the sign bit of A - B, so it stays correct when the subtraction overflows.
- zero = (result == 0), for every alucont value including 011.
- No X propagation is permitted for defined inputs. Outputs settle within the same cycle the inputs change.

Test Plan:
- Reset and register 0:
  - Write 0xDEADBEEF to r5, then assert reset mid-cycle: rd1 (ra1=5) reads 0 immediately, before any clock edge.
  - Write 0x12345678 to r0: rd1 (ra1=0) reads 0.
- Write/read timing:
  - we3=1, wa3=8, wd3=0xA5A5A5A5, ra1=ra2=8. Before the edge, rd1 and rd2 show the old value 0; after the edge, both show 0xA5A5A5A5.
  - With we3=0, a subsequent edge leaves the value unchanged.
- Dual port:
  - r3=7, r4=9, ra1=3, ra2=4: rd1=7, rd2=9 in the same cycle.
  - Swap the addresses: the outputs swap combinationally.
- ALU arithmetic:
  - 0xFFFFFFFF + 1 = 0x00000000 with zero=1.
  - 5 - 7 = 0xFFFFFFFE with zero=0.
  - PC-style 0x00400000 + 4 = 0x00400004.
- ALU logic:
  - A=0xF0F0F0F0, B=0x0FF00FF0:
  - AND = 0x00F000F0; OR = 0xFFF0FFF0.
  - A&~B = 0xF000F000; A|~B = 0xF0FFF0FF.
  - alucont 011 gives 0 with zero=1.
- SLT:
  - 0xFFFFFFFF (-1) vs 1 gives 1.
  - 1 vs -1 gives 0 with zero=1.
  - 0x80000000 vs 0x7FFFFFFF (overflowing subtraction) gives 1.
  - Equal operands give 0.

Source files
------------

// File: rtl/mips_alu_regfile_if.sv
// Bus bundle for the MIPS execution core: register-file ports plus ALU operands/result.
// The datapath side uses the master modport and the core uses the slave modport.
interface mips_alu_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we3;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [ADDR_W-1:0] wa3;
  logic [DATA_W-1:0] wd3;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [2:0]        alucont;
  logic [DATA_W-1:0] result;
  logic              zero;

  modport master (
    output we3, ra1, ra2, wa3, wd3, a, b, alucont,
    input  rd1, rd2, result, zero
  );

  modport slave (
    input  we3, ra1, ra2, wa3, wd3, a, b, alucont,
    output rd1, rd2, result, zero
  );
endinterface

// File: rtl/mips_alu_regfile.sv
// Multicycle MIPS execution core: 2-read/1-write register file with r0 hardwired to zero,
// and an independent combinational ALU with zero flag. The two halves share only clk/reset.
module mips_alu_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  mips_alu_regfile_if.slave  bus
);
  localparam int NREG = 2**ADDR_W;

  logic [DATA_W-1:0] r_regs [NREG];
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (bus.we3 && (bus.wa3 != '0)) begin
      r_regs[bus.wa3] <= bus.wd3;
    end
  end

  // Reads are combinational with no write bypass; r0 and the reset window read as zero.
  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    if (!reset && (bus.ra1 != '0)) w_rd1 = r_regs[bus.ra1];
    if (!reset && (bus.ra2 != '0)) w_rd2 = r_regs[bus.ra2];
  end

  assign bus.rd1 = w_rd1;
  assign bus.rd2 = w_rd2;

  logic signed [DATA_W-1:0] w_a_s;
  logic signed [DATA_W-1:0] w_b_s;
  logic                     w_slt;
  logic        [DATA_W-1:0] w_result;

  assign w_a_s = $signed(bus.a);
  assign w_b_s = $signed(bus.b);
  // True signed compare, so SLT stays correct when A - B would overflow.
  assign w_slt = (w_a_s < w_b_s);

  always_comb begin
    w_result = '0;
    case (bus.alucont)
      3'b000:  w_result = bus.a & bus.b;
      3'b001:  w_result = bus.a | bus.b;
      3'b010:  w_result = bus.a + bus.b;
      3'b011:  w_result = '0;
      3'b100:  w_result = bus.a & ~bus.b;
      3'b101:  w_result = bus.a | ~bus.b;
      3'b110:  w_result = bus.a - bus.b;
      3'b111:  w_result = {{(DATA_W-1){1'b0}}, w_slt};
      default: w_result = '0;
    endcase
  end

  assign bus.result = w_result;
  assign bus.zero   = (w_result == '0);
endmodule

// File: tb/tb_mips_alu_regfile.sv
// Randomized bench for mips_alu_regfile: an array-based register model and arithmetic ALU model
// are checked on every falling edge, plus hand-computed literal expectations.
module tb_mips_alu_regfile;
  logic clk;
  logic reset;

  mips_alu_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  mips_alu_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] model [32];
  logic [31:0] edge_vals [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [4:0] ad);
    if (reset || ad == 5'd0) return 32'd0;
    return model[ad];
  endfunction

  function automatic logic [31:0] m_alu(input logic [31:0] x, input logic [31:0] y,
                                        input logic [2:0] op);
    logic lt;
    // Signed less-than: differing signs decide directly, same signs compare as unsigned.
    if (x[31] != y[31]) lt = x[31];
    else                lt = (x < y);
    case (op)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x + y;
      3'd3: return 32'd0;
      3'd4: return x & ~y;
      3'd5: return x | ~y;
      3'd6: return x - y;
      default: return lt ? 32'd1 : 32'd0;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  end

  always @(posedge reset) begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  end

  always @(posedge clk) begin
    if (!reset && bus.we3 && bus.wa3 != 5'd0) model[bus.wa3] = bus.wd3;
  end

  // Outputs are meaningful on every cycle; compare at the falling edge.
  always @(negedge clk) begin
    logic [31:0] er;
    er = m_alu(bus.a, bus.b, bus.alucont);
    chk("rd1_model", bus.rd1, m_rd(bus.ra1));
    chk("rd2_model", bus.rd2, m_rd(bus.ra2));
    chk("result_model", bus.result, er);
    chk("zero_model", {31'd0, bus.zero}, {31'd0, (er == 32'd0)});
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic alu_lit(input string nm, input logic [31:0] x, input logic [31:0] y,
                         input logic [2:0] op, input logic [31:0] er, input logic ez);
    step();
    bus.a = x; bus.b = y; bus.alucont = op;
    #1;
    chk({nm, "_res"}, bus.result, er);
    chk({nm, "_zero"}, {31'd0, bus.zero}, {31'd0, ez});
  endtask

  initial begin
    reset = 1'b1;
    bus.we3 = 1'b0; bus.ra1 = 5'd5; bus.ra2 = 5'd0; bus.wa3 = 5'd0; bus.wd3 = 32'd0;
    bus.a = 32'd0; bus.b = 32'd0; bus.alucont = 3'd0;
    edge_vals[0] = 32'h0000_0000; edge_vals[1] = 32'h0000_0001;
    edge_vals[2] = 32'hFFFF_FFFF; edge_vals[3] = 32'h8000_0000;
    edge_vals[4] = 32'h7FFF_FFFF; edge_vals[5] = 32'h0040_0000;

    step(); step();
    #1;
    chk("reset_rd1", bus.rd1, 32'd0);
    chk("reset_rd2", bus.rd2, 32'd0);
    step();
    reset = 1'b0;

    // r5 write, then an asynchronous reset mid-cycle
    step();
    bus.we3 = 1'b1; bus.wa3 = 5'd5; bus.wd3 = 32'hDEAD_BEEF; bus.ra1 = 5'd5;
    step();
    bus.we3 = 1'b0;
    #1;
    chk("r5_written", bus.rd1, 32'hDEAD_BEEF);
    reset = 1'b1;
    #1;
    chk("async_reset_rd1", bus.rd1, 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("r5_after_reset", bus.rd1, 32'd0);

    // r0 write is discarded
    step();
    bus.we3 = 1'b1; bus.wa3 = 5'd0; bus.wd3 = 32'h1234_5678; bus.ra1 = 5'd0;
    step();
    bus.we3 = 1'b0;
    #1;
    chk("r0_reads_zero", bus.rd1, 32'd0);

    // read-during-write shows the old value until the edge
    step();
    bus.we3 = 1'b1; bus.wa3 = 5'd8; bus.wd3 = 32'hA5A5_A5A5; bus.ra1 = 5'd8; bus.ra2 = 5'd8;
    #1;
    chk("rdw_old_rd1", bus.rd1, 32'd0);
    chk("rdw_old_rd2", bus.rd2, 32'd0);
    step();
    bus.we3 = 1'b0;
    #1;
    chk("rdw_new_rd1", bus.rd1, 32'hA5A5_A5A5);
    chk("rdw_new_rd2", bus.rd2, 32'hA5A5_A5A5);
    step();
    #1;
    chk("we0_hold", bus.rd1, 32'hA5A5_A5A5);

    // dual port and combinational address swap
    step();
    bus.we3 = 1'b1; bus.wa3 = 5'd3; bus.wd3 = 32'd7;
    step();
    bus.wa3 = 5'd4; bus.wd3 = 32'd9;
    step();
    bus.we3 = 1'b0; bus.ra1 = 5'd3; bus.ra2 = 5'd4;
    #1;
    chk("dual_rd1", bus.rd1, 32'd7);
    chk("dual_rd2", bus.rd2, 32'd9);
    bus.ra1 = 5'd4; bus.ra2 = 5'd3;
    #1;
    chk("swap_rd1", bus.rd1, 32'd9);
    chk("swap_rd2", bus.rd2, 32'd7);

    alu_lit("add_wrap", 32'hFFFF_FFFF, 32'd1, 3'b010, 32'd0, 1'b1);
    alu_lit("sub_neg",  32'd5, 32'd7, 3'b110, 32'hFFFF_FFFE, 1'b0);
    alu_lit("add_pc",   32'h0040_0000, 32'd4, 3'b010, 32'h0040_0004, 1'b0);
    alu_lit("and",      32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b000, 32'h00F0_00F0, 1'b0);
    alu_lit("or",       32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b001, 32'hFFF0_FFF0, 1'b0);
    alu_lit("andn",     32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b100, 32'hF000_F000, 1'b0);
    alu_lit("orn",      32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b101, 32'hF0FF_F0FF, 1'b0);
    alu_lit("reserved", 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b011, 32'd0, 1'b1);
    alu_lit("slt_m1_1", 32'hFFFF_FFFF, 32'd1, 3'b111, 32'd1, 1'b0);
    alu_lit("slt_1_m1", 32'd1, 32'hFFFF_FFFF, 3'b111, 32'd0, 1'b1);
    alu_lit("slt_ovf",  32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 32'd1, 1'b0);
    alu_lit("slt_eq",   32'h1234_5678, 32'h1234_5678, 3'b111, 32'd0, 1'b1);

    // randomized phase, checked by the falling-edge compare process
    for (int i = 0; i < 400; i++) begin
      step();
      reset       = ($urandom_range(0, 59) == 0);
      bus.we3     = $urandom_range(0, 1);
      bus.wa3     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      bus.wd3     = $urandom;
      bus.ra1     = 5'($urandom_range(0, 31));
      bus.ra2     = ($urandom_range(0, 3) == 0) ? bus.wa3 : 5'($urandom_range(0, 31));
      bus.a       = ($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 5)] : 32'($urandom);
      bus.b       = ($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 5)] : 32'($urandom);
      if ($urandom_range(0, 7) == 0) bus.b = bus.a;
      bus.alucont = 3'($urandom_range(0, 7));
    end
    step();
    reset = 1'b0;
    bus.we3 = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
